// File: rtl/g15_pkg.sv
// ----------------------------------------------------------------------------
// g15_pkg
// Shared G-15 definitions used by the drum-line host ports.
//   WORD_BITS          bits per drum word (LSB first on the track)
//   g15_word_t         one drum word
//   host_port_state_t  host-port sequencer states (fixed 2-bit encoding)
// ----------------------------------------------------------------------------
package g15_pkg;

  localparam int WORD_BITS = 29;

  typedef logic [WORD_BITS-1:0] g15_word_t;

  typedef enum logic [1:0] {
    HP_IDLE = 2'd0,
    HP_WAIT = 2'd1,
    HP_XFER = 2'd2,
    HP_RESP = 2'd3
  } host_port_state_t;

endpackage

// File: rtl/word_serdes.sv
// ----------------------------------------------------------------------------
// word_serdes
// One-word serial shift-out / capture-in register with a bit counter.
// The word to send is parallel-loaded, then shifted out LSB first, one bit
// per shift_en cycle. In the same cycles the serial input is shifted into a
// capture register, so after W shifts cap_word holds the word that passed.
// Ports:
//   clk        in  1   clock (one drum bit time)
//   rst        in  1   synchronous active-high reset (bit counter only)
//   load       in  1   load load_data and restart the bit counter
//   load_data  in  W   word to shift out
//   shift_en   in  1   advance one bit
//   din        in  1   serial input captured on each shift
//   dout       out 1   current outgoing bit (LSB of the shift register)
//   last       out 1   the current shift is bit W-1
//   cap_word   out W   captured word including the current din bit
// ----------------------------------------------------------------------------
module word_serdes #(
  parameter int W  = 29,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         din,
  output logic         dout,
  output logic         last,
  output logic [W-1:0] cap_word
);

  logic [W-1:0]  shreg;
  logic [W-1:0]  cap;
  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= last ? '0 : bit_cnt + CW'(1);
    end
  end

  // NOTE: the data registers carry no reset; their contents only matter after
  // a load (shreg) or a full word of shifts (cap), so a reset would add logic
  // without changing behaviour.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
    if (shift_en) begin
      cap <= cap_word;
    end
  end

  // Capture shifts in from the top so the first bit seen ends up in bit 0.
  assign cap_word = {din, cap[W-1:1]};
  assign last     = (bit_cnt == CW'(W - 1));
  assign dout     = shreg[0];

endmodule

// File: rtl/short_line_host_port.sv
// ----------------------------------------------------------------------------
// short_line_host_port
// Host-side word access to one recirculating short line (LINE_WORDS words of
// WORD_BITS bits). A request waits for its word to come round, then for one
// word time captures the line output and, on writes, replaces the track input
// with the new data (host_wr gates track din like LB & D5 gates a
// destination). The response returns the word as it was at the start of the
// pass, i.e. the old value on writes.
// Ports:
//   CLOCK      in  1   system clock, one cycle per drum bit
//   rst        in  1   synchronous active-high reset
//   T28        in  1   bit time 28 (last bit) of every word
//   WL         in  1   with T28 of the last line word; next word is 0
//   line_out   in  1   serial output of the served track
//   host_wr    out 1   track din must take host_bit instead of recirculating
//   host_bit   out 1   serial write data
//   req_valid  in  1   request handshake (fires on req_valid & req_ready)
//   req_ready  out 1
//   req_write  in  1   1 = write req_data, 0 = read only
//   req_word   in  2   word index, reduced mod LINE_WORDS
//   req_data   in  WB  write data
//   rsp_valid  out 1   response handshake, held until rsp_ready
//   rsp_ready  in  1
//   rsp_data   out WB  word contents at the start of the transfer
//   locked     out 1   word counter synchronised by a WL
//   sync_err   out 1   sticky: T28 disagreed with the bit counter in a transfer
// ----------------------------------------------------------------------------
module short_line_host_port #(
  parameter int WORD_BITS  = g15_pkg::WORD_BITS,
  parameter int LINE_WORDS = 4
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 T28,
  input  logic                 WL,
  input  logic                 line_out,
  output logic                 host_wr,
  output logic                 host_bit,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_word,
  input  logic [WORD_BITS-1:0] req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_BITS-1:0] rsp_data,
  output logic                 locked,
  output logic                 sync_err
);

  import g15_pkg::*;

  localparam int WC_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  host_port_state_t       state;
  logic [WC_W-1:0]        wc;        // index of the word currently passing
  logic [WC_W-1:0]        wc_nxt;    // word that starts after this T28
  logic [WC_W-1:0]        req_tgt;
  logic [WC_W-1:0]        tgt_word;
  logic                   wr_flag;
  logic                   fire;
  logic                   xfer;
  logic                   ser_dout;
  logic                   bit_last;
  logic [WORD_BITS-1:0]   cap_word;

  assign fire     = req_valid & req_ready;
  assign xfer     = (state == HP_XFER);
  assign req_tgt  = WC_W'(int'(req_word) % LINE_WORDS);
  assign wc_nxt   = (WL || wc == WC_W'(LINE_WORDS - 1)) ? '0 : wc + WC_W'(1);

  assign req_ready = (state == HP_IDLE) && locked;
  assign rsp_valid = (state == HP_RESP);
  // Decoded straight from state so a reset edge drops the write gate at once.
  assign host_wr   = xfer && wr_flag;
  assign host_bit  = host_wr && ser_dout;

  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see the pre-edge values of each other, as real flops do.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state    <= HP_IDLE;
      wc       <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
      rsp_data <= '0;
      wr_flag  <= 1'b0;
      tgt_word <= '0;
    end else begin
      if (T28) wc <= wc_nxt;
      if (WL)  locked <= 1'b1;

      case (state)
        HP_IDLE: begin
          if (fire) begin
            wr_flag  <= req_write;
            tgt_word <= req_tgt;
            // Target word starts right after this edge: skip the wait.
            state    <= (T28 && wc_nxt == req_tgt) ? HP_XFER : HP_WAIT;
          end
        end
        HP_WAIT: begin
          if (T28 && wc_nxt == tgt_word) state <= HP_XFER;
        end
        HP_XFER: begin
          // T28 must coincide with the last bit and only with it.
          if (T28 != bit_last) sync_err <= 1'b1;
          if (bit_last) begin
            rsp_data <= cap_word;
            state    <= HP_RESP;
          end
        end
        HP_RESP: begin
          if (rsp_ready) state <= HP_IDLE;
        end
        default: state <= HP_IDLE;
      endcase
    end
  end

  word_serdes #(
    .W (WORD_BITS)
  ) u_serdes (
    .clk       (CLOCK),
    .rst       (rst),
    .load      (fire),
    .load_data (req_data),
    .shift_en  (xfer),
    .din       (line_out),
    .dout      (ser_dout),
    .last      (bit_last),
    .cap_word  (cap_word)
  );

endmodule
